// File: rtl/morse_key_classifier_if.sv
// Bundle between the raw Morse key and the symbol counter / letter lookup stages.
// The classifier drives everything except key_in.
interface morse_key_classifier_if;
  logic       key_in;
  logic       sym_valid;
  logic       sym_dash;
  logic       letter_valid;
  logic [3:0] letter_code;
  logic [2:0] letter_len;
  logic       letter_err;
  logic       word_valid;

  modport master (
    input  key_in,
    output sym_valid, sym_dash, letter_valid, letter_code, letter_len, letter_err, word_valid
  );

  modport slave (
    output key_in,
    input  sym_valid, sym_dash, letter_valid, letter_code, letter_len, letter_err, word_valid
  );
endinterface

// File: rtl/morse_key_classifier.sv
// Times key presses and gaps in prescaled units, classifies each press as dot or dash,
// and packs up to four symbols into a letter code with letter and word boundary pulses.
module morse_key_classifier #(
  parameter int TICK_DIV         = 4,
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  morse_key_classifier_if.master bus
);

  localparam int            TW         = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX   = TW'(TICK_DIV - 1);
  localparam logic [3:0]    DASH_U     = 4'(DASH_UNITS);
  localparam logic [3:0]    LETTER_HIT = 4'(LETTER_GAP_UNITS - 1);
  localparam logic [3:0]    WORD_HIT   = 4'(WORD_GAP_UNITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE, ST_WORD} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, key_s_q, key_prev_q;
  logic [TW-1:0] tick_q;
  logic [3:0]    unit_q;
  logic [3:0]    code_q, code_d;
  logic [2:0]    len_q, len_d;
  logic          err_q, err_d;
  logic          sym_valid_q, sym_valid_d, sym_dash_q, sym_dash_d;
  logic          letter_valid_q, letter_valid_d, letter_err_q, letter_err_d;
  logic [3:0]    letter_code_q, letter_code_d;
  logic [2:0]    letter_len_q, letter_len_d;
  logic          word_valid_q, word_valid_d;

  logic key_rise_s, key_fall_s, tick_s, is_dash_s, letter_hit_s, word_hit_s;

  assign key_rise_s   = key_s_q & ~key_prev_q;
  assign key_fall_s   = ~key_s_q & key_prev_q;
  assign tick_s       = (tick_q == TICK_MAX);
  assign is_dash_s    = (unit_q >= DASH_U);
  // Thresholds fire on the tick that carries unit_q onto the gap length, so the pulse lands with it.
  assign letter_hit_s = tick_s & (unit_q == LETTER_HIT);
  assign word_hit_s   = tick_s & (unit_q == WORD_HIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= 1'b0;
      key_s_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      sync1_q    <= bus.key_in;
      key_s_q    <= sync1_q;
      key_prev_q <= key_s_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q <= '0;
      unit_q <= 4'd0;
    end else if (key_rise_s || key_fall_s) begin
      tick_q <= '0;
      unit_q <= 4'd0;
    end else if (tick_s) begin
      tick_q <= '0;
      if (unit_q != 4'd15) begin
        unit_q <= unit_q + 4'd1;
      end
    end else begin
      tick_q <= tick_q + TW'(1'b1);
    end
  end

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    len_d          = len_q;
    err_d          = err_q;
    sym_valid_d    = 1'b0;
    sym_dash_d     = sym_dash_q;
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code_q;
    letter_len_d   = letter_len_q;
    letter_err_d   = letter_err_q;
    word_valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_rise_s) begin
          state_d = ST_MARK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (key_fall_s) begin
          sym_valid_d = 1'b1;
          sym_dash_d  = is_dash_s;
          if (len_q < 3'd4) begin
            code_d[len_q[1:0]] = is_dash_s;
            len_d              = len_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_SPACE;
        end else begin
          state_d = ST_MARK;
        end
      end
      ST_SPACE: begin
        if (letter_hit_s) begin
          letter_valid_d = 1'b1;
          letter_code_d  = code_q;
          letter_len_d   = len_q;
          letter_err_d   = err_q;
          code_d         = 4'd0;
          len_d          = 3'd0;
          err_d          = 1'b0;
          state_d        = key_rise_s ? ST_MARK : ST_WORD;
        end else if (key_rise_s) begin
          state_d = ST_MARK;
        end else begin
          state_d = ST_SPACE;
        end
      end
      ST_WORD: begin
        if (word_hit_s) begin
          word_valid_d = 1'b1;
          state_d      = key_rise_s ? ST_MARK : ST_IDLE;
        end else if (key_rise_s) begin
          state_d = ST_MARK;
        end else begin
          state_d = ST_WORD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      code_q         <= 4'd0;
      len_q          <= 3'd0;
      err_q          <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_dash_q     <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_code_q  <= 4'd0;
      letter_len_q   <= 3'd0;
      letter_err_q   <= 1'b0;
      word_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      len_q          <= len_d;
      err_q          <= err_d;
      sym_valid_q    <= sym_valid_d;
      sym_dash_q     <= sym_dash_d;
      letter_valid_q <= letter_valid_d;
      letter_code_q  <= letter_code_d;
      letter_len_q   <= letter_len_d;
      letter_err_q   <= letter_err_d;
      word_valid_q   <= word_valid_d;
    end
  end

  assign bus.sym_valid    = sym_valid_q;
  assign bus.sym_dash     = sym_dash_q;
  assign bus.letter_valid = letter_valid_q;
  assign bus.letter_code  = letter_code_q;
  assign bus.letter_len   = letter_len_q;
  assign bus.letter_err   = letter_err_q;
  assign bus.word_valid   = word_valid_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Scoreboard bench: each scenario pushes the events it expects (kind, payload, cycle stamp)
// and compares them against the events a negedge monitor captures from the DUT.
module tb_morse_key_classifier;

  localparam int TD       = 4;
  localparam int N_GAP    = 3;
  localparam int W_GAP    = 7;
  localparam int SYM_LAT  = 3;
  localparam int LET_LAT  = 2 + N_GAP * TD + 1;
  localparam int WORD_LAT = 2 + W_GAP * TD + 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  code;
    logic [2:0]  len;
    logic        err;
    logic [31:0] cyc;
  } ev_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  morse_key_classifier_if bus ();

  morse_key_classifier #(
    .TICK_DIV(TD), .DASH_UNITS(3), .LETTER_GAP_UNITS(N_GAP), .WORD_GAP_UNITS(W_GAP)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (bus.sym_valid)    obs_q.push_back({2'd0, {3'b000, bus.sym_dash}, 3'd0, 1'b0, 32'(cyc)});
      if (bus.letter_valid) obs_q.push_back({2'd1, bus.letter_code, bus.letter_len, bus.letter_err, 32'(cyc)});
      if (bus.word_valid)   obs_q.push_back({2'd2, 4'd0, 3'd0, 1'b0, 32'(cyc)});
    end
  end

  function automatic ev_t mk_sym(input logic dash, input int c);
    return {2'd0, {3'b000, dash}, 3'd0, 1'b0, 32'(c + SYM_LAT)};
  endfunction

  function automatic ev_t mk_letter(input logic [3:0] code, input logic [2:0] len, input logic err, input int c);
    return {2'd1, code, len, err, 32'(c + LET_LAT)};
  endfunction

  function automatic ev_t mk_word(input int c);
    return {2'd2, 4'd0, 3'd0, 1'b0, 32'(c + WORD_LAT)};
  endfunction

  task automatic drive_key(input logic v, input int n, output int c);
    @(negedge CLK);
    bus.key_in = v;
    c = cyc;
    repeat (n) @(posedge CLK);
  endtask

  task automatic test_reset();
    int bad;
    logic [11:0] outs;
    RST_N = 1'b0;
    bus.key_in = 1'b0;
    repeat (3) @(negedge CLK);
    outs = {bus.sym_valid, bus.sym_dash, bus.letter_valid, bus.letter_code, bus.letter_len, bus.letter_err, bus.word_valid};
    n_checks++;
    if (outs !== 12'h000) $display("FAIL reset_outputs: got %h want 000", outs);
    else n_pass++;
    RST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      outs = {bus.sym_valid, bus.sym_dash, bus.letter_valid, bus.letter_code, bus.letter_len, bus.letter_err, bus.word_valid};
      if (outs !== 12'h000) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_idle_quiet: got %0d nonzero cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL reset_no_events: got %0d events want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_letter_a();
    int c;
    ev_t o, e;
    drive_key(1'b1, 8, c);
    drive_key(1'b0, 4, c);
    exp_q.push_back(mk_sym(1'b0, c));
    drive_key(1'b1, 16, c);
    drive_key(1'b0, 40, c);
    exp_q.push_back(mk_sym(1'b1, c));
    exp_q.push_back(mk_letter(4'b0010, 3'd2, 1'b0, c));
    exp_q.push_back(mk_word(c));
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL letter_a_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL letter_a_event: got %h want %h", o, e);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    int c;
    ev_t o, e;
    for (int i = 0; i < 5; i++) begin
      drive_key(1'b1, 4, c);
      drive_key(1'b0, (i == 4) ? 20 : 4, c);
      exp_q.push_back(mk_sym(1'b0, c));
    end
    exp_q.push_back(mk_letter(4'b0000, 3'd4, 1'b1, c));
    drive_key(1'b1, 20, c);
    drive_key(1'b0, 40, c);
    exp_q.push_back(mk_sym(1'b1, c));
    exp_q.push_back(mk_letter(4'b0001, 3'd1, 1'b0, c));
    exp_q.push_back(mk_word(c));
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL overflow_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL overflow_event: got %h want %h", o, e);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int c;
    ev_t o, e;
    drive_key(1'b1, 200, c);
    #1;
    n_checks++;
    if (dut.unit_q !== 4'd15) $display("FAIL saturation_unit: got %0d want 15", dut.unit_q);
    else n_pass++;
    drive_key(1'b0, 40, c);
    exp_q.push_back(mk_sym(1'b1, c));
    exp_q.push_back(mk_letter(4'b0001, 3'd1, 1'b0, c));
    exp_q.push_back(mk_word(c));
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL saturation_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL saturation_event: got %h want %h", o, e);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    int c;
    ev_t o, e;
    drive_key(1'b1, 16, c);
    // A 12-cycle release puts the key_s rise on the cycle the letter gap completes.
    drive_key(1'b0, 12, c);
    exp_q.push_back(mk_sym(1'b1, c));
    exp_q.push_back(mk_letter(4'b0001, 3'd1, 1'b0, c));
    drive_key(1'b1, 8, c);
    drive_key(1'b0, 40, c);
    exp_q.push_back(mk_sym(1'b0, c));
    exp_q.push_back(mk_letter(4'b0000, 3'd1, 1'b0, c));
    exp_q.push_back(mk_word(c));
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL simultaneous_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL simultaneous_event: got %h want %h", o, e);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_mark();
    int c;
    ev_t o, e;
    logic [11:0] outs;
    drive_key(1'b1, 10, c);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1 bus.key_in = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    outs = {bus.sym_valid, bus.sym_dash, bus.letter_valid, bus.letter_code, bus.letter_len, bus.letter_err, bus.word_valid};
    n_checks++;
    if (outs !== 12'h000) $display("FAIL reset_mid_outputs: got %h want 000", outs);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL reset_mid_no_events: got %0d events want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    drive_key(1'b1, 8, c);
    drive_key(1'b0, 40, c);
    exp_q.push_back(mk_sym(1'b0, c));
    exp_q.push_back(mk_letter(4'b0000, 3'd1, 1'b0, c));
    exp_q.push_back(mk_word(c));
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL reset_mid_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL reset_mid_event: got %h want %h", o, e);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_overflow();
    test_saturation();
    test_simultaneous();
    test_reset_mid_mark();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_key_classifier.md
# morse_key_classifier

Converts the raw Morse key input into classified symbols and completed letter patterns. It synchronises the key, times each press and each gap in time units, and labels each press as dot or dash. It emits a per-symbol enable pulse for the downstream 2-bit symbol counter, plus a packed letter code and word boundaries for the character lookup stage. It sits between the board key input and the symbol counter / decode logic.

## Interface
- TICK_DIV, 4, CLK cycles per time unit (≥2).
- DASH_UNITS, 3, press of at least this many whole units is a dash, else a dot.
- LETTER_GAP_UNITS, 3, release lasting this many units ends the current letter.
- WORD_GAP_UNITS, 7, release lasting this many units ends the word (> LETTER_GAP_UNITS, ≤15).
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- key_in  input  1  raw key, 1 = pressed; asynchronous to CLK.
- sym_valid  output  1  one-cycle pulse per classified symbol; drives the symbol counter enable.
- sym_dash  output  1  qualifies sym_valid: 1 = dash, 0 = dot.
- letter_valid  output  1  one-cycle pulse when a letter completes.
- letter_code  output  4  symbols of the letter, first symbol in bit 0, dash = 1; unused bits 0.
- letter_len  output  3  symbol count 1..4, valid with letter_valid.
- letter_err  output  1  with letter_valid: more than 4 symbols were keyed.
- word_valid  output  1  one-cycle pulse at the word gap.

## Operation
- key_in passes through a 2-flop synchroniser to give key_s. A registered copy key_d is kept for edge detection.
- Prescaler tick_cnt counts 0..TICK_DIV-1. tick is high while tick_cnt == TICK_DIV-1, then tick_cnt wraps to 0.
- unit_cnt is 4-bit and increments on tick, saturating at 15.
- Both tick_cnt and unit_cnt clear on any key_s edge, so durations are measured from the edge.
- The FSM has four states: IDLE, MARK, SPACE and WORD.
- IDLE: on key_s rise, go to MARK.
- MARK, on key_s fall:
  - Classify the press: dash if unit_cnt ≥ DASH_UNITS, else dot.
  - Pulse sym_valid and drive sym_dash.
  - If len < 4, write the symbol into code[len] and increment len.
  - If len == 4, drop the symbol and set the err flag.
  - Go to SPACE.
- SPACE:
  - On key_s rise, go to MARK; the next symbol joins the current letter.
  - When unit_cnt reaches LETTER_GAP_UNITS, pulse letter_valid with code, len and err on the outputs. Then clear code, len and err, and go to WORD.
- WORD:
  - On key_s rise, go to MARK; a new letter starts.
  - When unit_cnt reaches WORD_GAP_UNITS, pulse word_valid and go to IDLE.
- A press lasting 0 whole units is a dot. A press past 15 units saturates and stays a dash.
- Simultaneous events (threshold reached in the same cycle as a key_s rise):
  - Letter threshold: letter_valid still pulses, code/len/err clear, and the state goes to MARK.
  - Word threshold: word_valid still pulses and the state goes to MARK.
- The only way back to IDLE is the word gap or reset.

## Timing
- All outputs are registered.
- Reset values:
  - sym_valid, sym_dash, letter_valid, letter_code, letter_len, letter_err and word_valid are all 0.
  - The FSM is in IDLE.
  - Synchroniser flops, tick_cnt, unit_cnt and the internal code/len/err are 0.
- Reset asserted mid-letter discards the partial letter; no pulse is emitted.
- Latency:
  - key_in edge to key_s: 2 cycles.
  - sym_valid is high exactly 3 cycles after key_in falls, for 1 cycle.
- Letter and word timing, with N = LETTER_GAP_UNITS and W = WORD_GAP_UNITS:
  - letter_valid is high 1 cycle after tick brings unit_cnt to N, i.e. N·TICK_DIV + 1 cycles after the key_s fall.
  - word_valid occurs at W·TICK_DIV + 1 cycles after the key_s fall.
- letter_code, letter_len and letter_err are meaningful only while letter_valid is high. They hold their last values otherwise.
- sym_dash holds until the next sym_valid.
- No back-pressure: consumers must accept every pulse.

## Test plan
All scenarios use TICK_DIV=4 and default units.
- Reset: release RST_N with key_in=0 for 100 cycles -> every output stays 0; no pulses.
- Letter "A": press 8 cycles, release 4, press 16, release 40 -> two sym_valid pulses with sym_dash 0 then 1. letter_valid fires once with code=4'b0010, len=3'd2, err=0, 13 cycles after the second key_s fall. word_valid fires 29 cycles after that fall.
- Overflow: five 4-cycle dots separated by 4-cycle gaps -> five sym_valid pulses (all dots). letter_valid then fires with code=0000, len=4, err=1. The next letter "T" (one 20-cycle press) gives code=0001, len=1, err=0.
- Saturation: hold key 200 cycles -> unit_cnt stops at 15; one sym_valid with sym_dash=1.
- Simultaneous: key_s rises on the same cycle unit_cnt reaches 3 in SPACE -> letter_valid pulses with the old letter, and the new press is classified into a fresh letter (len=1).
- Reset mid-MARK: assert RST_N low during a 20-cycle press, release RST_N, release the key -> no sym_valid; the FSM is in IDLE and waits for a new rise.
